// File: rtl/wta_spike_out.sv
// wta_spike_out: winner-take-all output stage for the tinySNN neuron array.
//
// Each cycle this block registers every neuron output. It then picks the
// largest nonzero value from that registered sample; on a tie the lowest index
// wins. It offers the winner on a valid/ready interface. After the winner is
// accepted, a refractory window of p_refrac cycles follows, and only then does
// the block arbitrate again. Lateral inhibition is high for the whole time a
// winner is pending and for the whole refractory window.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_enable       arbitration enable, only looked at while idle
//   i_neuronout    packed unsigned neuron outputs, lane n at [(n+1)*p_vw-1 : n*p_vw]
//   o_spike_valid  winner available
//   i_spike_ready  consumer accepts the winner
//   o_spike_idx    winning lane index (0-based); holds its value after acceptance
//   o_spike_value  winner's sampled value; holds its value after acceptance
//   o_inhibit      lateral inhibition, high while a winner is pending or refractory
//   o_miss_cnt     saturating count of candidate cycles suppressed by inhibition
//   o_spike_cnt    wrapping count of accepted spikes
//
// p_vw is derived from the neuron datapath widths and is not meant to be
// overridden. p_idxw must satisfy 2**p_idxw >= p_neurons.

module wta_spike_out #(
  parameter int p_neurons = 8,
  parameter int p_width   = 8,
  parameter int p_shift   = 8,
  parameter int p_vw      = p_width + p_shift + 6,
  parameter int p_idxw    = 4,
  parameter int p_refrac  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic [p_neurons*p_vw-1:0] i_neuronout,
  output logic                      o_spike_valid,
  input  logic                      i_spike_ready,
  output logic [p_idxw-1:0]         o_spike_idx,
  output logic [p_vw-1:0]           o_spike_value,
  output logic                      o_inhibit,
  output logic [7:0]                o_miss_cnt,
  output logic [15:0]               o_spike_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REFRAC = 2'd2
  } state_e;

  localparam logic [7:0] lp_refrac_load = 8'(p_refrac);

  state_e                      state_q, state_d;
  logic [p_neurons*p_vw-1:0]   r_in_q;
  logic                        valid_q, valid_d;
  logic [p_idxw-1:0]           idx_q, idx_d;
  logic [p_vw-1:0]             value_q, value_d;
  logic                        inhibit_q, inhibit_d;
  logic [7:0]                  refrac_q, refrac_d;
  logic [7:0]                  miss_q, miss_d;
  logic [15:0]                 spike_cnt_q, spike_cnt_d;

  logic                        win_found;
  logic [p_idxw-1:0]           win_idx;
  logic [p_vw-1:0]             win_val;

  // Argmax over the registered sample. The running maximum starts at zero, so
  // a zero lane can never win. The comparison is strict, so a later lane with
  // an equal value does not replace an earlier one: the lowest index wins ties.
  always_comb begin
    win_val = '0;
    win_idx = '0;
    for (int n = 0; n < p_neurons; n++) begin
      if (r_in_q[n*p_vw +: p_vw] > win_val) begin
        win_val = r_in_q[n*p_vw +: p_vw];
        win_idx = p_idxw'(n);
      end
    end
    win_found = (win_val != '0);
  end

  // NOTE: every variable gets its hold value before the case statement, so a
  // branch that leaves a variable untouched cannot infer a latch.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    idx_d       = idx_q;
    value_d     = value_q;
    inhibit_d   = inhibit_q;
    refrac_d    = refrac_q;
    spike_cnt_d = spike_cnt_q;
    miss_d      = miss_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_enable && win_found) begin
          state_d   = ST_HOLD;
          valid_d   = 1'b1;
          idx_d     = win_idx;
          value_d   = win_val;
          inhibit_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // i_enable is deliberately ignored here. Once a winner is offered,
        // the handshake always completes.
        if (i_spike_ready) begin
          valid_d     = 1'b0;
          spike_cnt_d = spike_cnt_q + 16'd1;
          if (p_refrac == 0) begin
            state_d   = ST_IDLE;
            inhibit_d = 1'b0;
          end else begin
            state_d  = ST_REFRAC;
            refrac_d = lp_refrac_load;
          end
        end
      end
      ST_REFRAC: begin
        refrac_d = refrac_q - 8'd1;
        // The counter is loaded with p_refrac. Leaving on the count of 1
        // makes the window exactly p_refrac edges long.
        if (refrac_q == 8'd1) begin
          state_d   = ST_IDLE;
          inhibit_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        valid_d   = 1'b0;
        inhibit_d = 1'b0;
      end
    endcase

    if ((state_q != ST_IDLE) && win_found && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      r_in_q      <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      value_q     <= '0;
      inhibit_q   <= 1'b0;
      refrac_q    <= '0;
      miss_q      <= '0;
      spike_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      r_in_q      <= i_neuronout;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      value_q     <= value_d;
      inhibit_q   <= inhibit_d;
      refrac_q    <= refrac_d;
      miss_q      <= miss_d;
      spike_cnt_q <= spike_cnt_d;
    end
  end

  assign o_spike_valid = valid_q;
  assign o_spike_idx   = idx_q;
  assign o_spike_value = value_q;
  assign o_inhibit     = inhibit_q;
  assign o_miss_cnt    = miss_q;
  assign o_spike_cnt   = spike_cnt_q;

endmodule

// File: doc/wta_spike_out.md
Name: wta_spike_out

Overview:
- Output stage directly downstream of the 8 neuron42s instances in the tinySNN array.
- Samples all neuron outputs (thresholded membrane values; zero means not firing) each cycle and picks a single winner (winner-take-all).
- Presents the winner's index and value on a valid/ready interface, then drives a lateral-inhibition window with a refractory counter before it arbitrates again.

Parameters:
p_neurons, 8, number of neuron inputs (2..16)
p_width, 8, synaptic weight width (matches neuron)
p_shift, 8, synapse resolution bits (matches neuron)
p_vw, p_width+p_shift+6 (=22), neuron output value width (derived; do not override)
p_idxw, 4, winner index width; must satisfy 2**p_idxw >= p_neurons
p_refrac, 16, refractory length in cycles (0..255)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_enable  in  1  arbitration enable, sampled in IDLE only
i_neuronout  in  p_neurons*p_vw  packed neuron outputs; neuron n (0-based) at [(n+1)*p_vw-1 : n*p_vw]; unsigned
o_spike_valid  out  1  winner available
i_spike_ready  in  1  consumer accepts winner
o_spike_idx  out  p_idxw  winning neuron index, 0-based
o_spike_value  out  p_vw  winner's sampled value
o_inhibit  out  1  lateral inhibition; high in HOLD and REFRAC
o_miss_cnt  out  8  saturating count of suppressed candidate cycles
o_spike_cnt  out  16  wrapping count of accepted spikes

Behaviour:
- Reset (i_rst high at an edge): state IDLE, input sample register and all outputs 0, refractory counter 0. Reset wins over every other event, including mid-handshake and mid-refractory.
- Input stage: i_neuronout is registered into r_in on every edge, unconditionally.
- Argmax: combinational over r_in.
  - Candidate = any lane with a nonzero value.
  - Largest unsigned value wins; on a tie, the lowest index wins.
  - No candidate means no fire.
- FSM, states IDLE / HOLD / REFRAC:
  - IDLE: at an edge with i_enable=1 and a candidate in r_in, latch idx/value, assert o_spike_valid, go to HOLD. Latency: a value present at i_neuronout before edge k gives o_spike_valid high after edge k+1.
  - HOLD: o_spike_valid=1; idx and value stay stable until accepted.
    - At an edge with i_spike_ready=1: drop valid, increment o_spike_cnt, load counter with p_refrac, go to REFRAC. If p_refrac=0, go straight to IDLE.
    - i_enable has no effect in HOLD; a started handshake always completes.
  - REFRAC: counter decrements each edge; at the edge where the counter equals 1, go to IDLE. REFRAC therefore lasts exactly p_refrac cycles.
- o_inhibit is 1 in HOLD and REFRAC, 0 in IDLE. It is registered and changes on the same edges as the state.
- o_miss_cnt: incremented at each edge where state is HOLD or REFRAC and r_in holds any candidate. Saturates at 255 and is cleared only by reset.
- Outputs o_spike_idx/o_spike_value hold their last winner after acceptance; they are qualified only by o_spike_valid.
- Earliest re-fire after acceptance at edge a: o_spike_valid rises after edge a+p_refrac+1.
- No combinational path from i_spike_ready to any output.

Test Plan:
- Reset: hold i_rst 2 cycles while i_neuronout is all nonzero -> all outputs 0, state IDLE; first fire occurs 2 edges after reset release.
- Single winner: lane 5 = 0x1234, others 0, i_spike_ready=1 -> o_spike_valid pulses for 1 cycle 2 edges after presentation, idx=5, value=0x1234, o_spike_cnt=1, o_inhibit high for 1+16 cycles.
- Tie / max: lanes 2 and 6 = 0x300, lane 4 = 0x2FF -> idx=2. Then lane 7 = 0x3FFFFF (max value) with lane 0 = 1 -> idx=7.
- Backpressure: i_spike_ready=0 for 10 cycles while lane 3 fires and inputs keep changing -> valid held, idx/value frozen at the first sample, o_miss_cnt increments each cycle with a candidate; acceptance on cycle 11.
- Refractory/miss saturation: p_refrac=255, a constant candidate on lane 1 -> exactly one accepted spike per 257 cycles; o_miss_cnt saturates at 255. With p_refrac=0 -> a spike is accepted every 2nd cycle.
- Mid-operation reset and enable: assert i_rst during HOLD and during REFRAC -> immediate IDLE, outputs 0. i_enable=0 with candidates -> no valid; deasserting i_enable during HOLD still completes the handshake.
